// File: rtl/cfg_chain_pkg.sv
// Shared types and helpers for the serial configuration chain loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cfg_chain_pkg;

  // Loader sequencing: one LOW/HIGH pair per chain bit, then LATCH and FIN.
  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    LATCH,
    FIN
  } cfg_state_t;

  // Bit index width; kept at least 1 bit so tiny chains still elaborate.
  function automatic int cfg_idx_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Cycles from the accept edge to the DONE cycle.
  function automatic int cfg_load_cycles(input int width, input int div);
    return 2 * div * width + 2;
  endfunction

endpackage

// File: rtl/cfg_chain_divider.sv
// Serial-clock phase divider: ticks on the last system cycle of each DIV-cycle phase.
// Latency: tick_o is combinational from the counter; first tick DIV cycles after load_i.
// Backpressure: none; counts only while run_i is high and holds otherwise.
//
// Ports:
//   CLK, RESET  system clock, async active-low reset
//   load_i      reload the counter (phase start from idle)
//   run_i       a serial-clock phase is in progress
//   tick_o      current cycle is the last of the phase
module cfg_chain_divider
  import cfg_chain_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic load_i,
  input  logic run_i,
  output logic tick_o
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = run_i && (cnt_q == '0);

  // A tick is also a phase change, so it reloads for the following phase.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i || tick_o) begin
      cnt_d = RELOAD;
    end else if (run_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Serial loader: shifts a parallel word into an external config chain, then latches it.
// Latency: accept edge to DONE is 2*DIV*WIDTH+2 cycles; one word per 2*DIV*WIDTH+3 cycles.
// Backpressure: IN_READY only while idle; IN_VALID during a load is ignored, no queueing.
//
// Optional feature macro: CFG_CHAIN_READBACK_EN (compare CHAIN_Q against the previous word).
// Ports:
//   CLK, RESET     system clock, async active-low reset (aborts a load, no latch)
//   IN_VALID/READY/DATA  parallel word handshake
//   CHAIN_CLK/D/LATCH    serial clock, data and shadow latch strobe to the chain
//   CHAIN_Q        chain serial output, used only for readback
//   BUSY, DONE, MISMATCH status; MISMATCH is meaningful only in the DONE cycle
module cfg_chain_loader
  import cfg_chain_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIV       = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             CHAIN_CLK,
  output logic             CHAIN_D,
  input  logic             CHAIN_Q,
  output logic             CHAIN_LATCH,
  output logic             BUSY,
  output logic             DONE,
  output logic             MISMATCH
);

  localparam int IW = cfg_idx_w(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  cfg_state_t       state_q;
  logic [WIDTH-1:0] data_q;
  logic [IW-1:0]    idx_q;
  logic             in_ready_q;
  logic             chain_clk_q;
  logic             chain_d_q;
  logic             latch_q;
  logic             busy_q;
  logic             done_q;
  logic             accept;
  logic             tick;
  logic             run;

  // Bit k of a word in shift order.
  function automatic logic sbit(input logic [WIDTH-1:0] w, input logic [IW-1:0] k);
    if (MSB_FIRST != 0) begin
      sbit = w[LAST_IDX - k];
    end else begin
      sbit = w[k];
    end
  endfunction

  // in_ready_q is only ever set in IDLE, so it alone qualifies the accept.
  assign accept = IN_VALID && in_ready_q;
  assign run    = (state_q == LOW) || (state_q == HIGH);

  cfg_chain_divider #(.DIV(DIV)) u_div (
    .CLK    (CLK),
    .RESET  (RESET),
    .load_i (accept),
    .run_i  (run),
    .tick_o (tick)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      data_q      <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      chain_clk_q <= 1'b0;
      chain_d_q   <= 1'b0;
      latch_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Also raises IN_READY on the first edge after reset release.
          in_ready_q <= 1'b1;
          if (accept) begin
            data_q     <= IN_DATA;
            idx_q      <= '0;
            chain_d_q  <= sbit(IN_DATA, '0);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= LOW;
          end
        end
        LOW: begin
          if (tick) begin
            chain_clk_q <= 1'b1;
            state_q     <= HIGH;
          end
        end
        HIGH: begin
          if (tick) begin
            chain_clk_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              latch_q <= 1'b1;
              state_q <= LATCH;
            end else begin
              // Next bit changes with the falling CHAIN_CLK edge, a full phase before the rise.
              idx_q     <= idx_q + 1'b1;
              chain_d_q <= sbit(data_q, idx_q + 1'b1);
              state_q   <= LOW;
            end
          end
        end
        LATCH: begin
          latch_q <= 1'b0;
          done_q  <= 1'b1;
          state_q <= FIN;
        end
        FIN: begin
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IN_READY    = in_ready_q;
  assign CHAIN_CLK   = chain_clk_q;
  assign CHAIN_D     = chain_d_q;
  assign CHAIN_LATCH = latch_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;

`ifdef CFG_CHAIN_READBACK_EN
  logic [WIDTH-1:0] shadow_q;
  logic             flag_q;
  logic             mismatch_q;
  logic             exp_q;

  // After the rising edge for bit i, the chain's last flop holds the bit that
  // entered WIDTH-1 edges earlier: old word bit i+1, or for the final bit the
  // first bit of the word now being loaded.
  assign exp_q = (idx_q == LAST_IDX) ? sbit(data_q, '0) : sbit(shadow_q, idx_q + 1'b1);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      shadow_q   <= '0;
      flag_q     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      if (accept) begin
        flag_q <= 1'b0;
      end else if ((state_q == HIGH) && tick && (CHAIN_Q != exp_q)) begin
        flag_q <= 1'b1;
      end
      mismatch_q <= (state_q == LATCH) ? flag_q : 1'b0;
      if (state_q == FIN) begin
        shadow_q <= data_q;
      end
    end
  end

  assign MISMATCH = mismatch_q;
`else
  logic unused_chain_q;
  assign unused_chain_q = CHAIN_Q;
  assign MISMATCH       = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: random and directed loads checked by a scoreboard.
// Main instance WIDTH=8, DIV=1, MSB_FIRST=1; second instance DIV=3, MSB_FIRST=0.
// Values observed at the negedge after edge k are the spec's "cycle k+1" values.
module tb_cfg_chain_loader;

  localparam int W   = 8;
  localparam int DV  = 1;
  localparam int LAT = 2 * DV * W + 2;

  typedef struct {
    logic [7:0] data;
    int         acc;
    logic       mm;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       IN_VALID;
  logic [7:0] IN_DATA;
  logic       IN_READY, CHAIN_CLK, CHAIN_D, CHAIN_Q, CHAIN_LATCH, BUSY, DONE, MISMATCH;

  logic       v3;
  logic [7:0] d3;
  logic       rdy3, cclk3, cd3, clatch3, busy3, done3, mm3;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ready_cyc = 1000000;
  exp_t sbq[$];
  exp_t e;
  logic exp_mm_next = 1'b0;
  logic chain_q_rand = 1'b0;

  int         rises, first_rise, last_rise, latch_cyc;
  logic [7:0] coll;
  logic       prev_clk;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

`ifdef CFG_CHAIN_READBACK_EN
  // External chain: 8 flops on CHAIN_CLK, optional stuck-at-1 on flop 3.
  logic [7:0] chain_r;
  logic [7:0] chain_eff;
  logic       force_f3 = 1'b0;
  assign chain_eff = chain_r | {4'b0000, force_f3, 3'b000};
  always @(posedge CHAIN_CLK or negedge RESET) begin
    if (!RESET) chain_r <= '0;
    else        chain_r <= {chain_eff[6:0], CHAIN_D};
  end
  assign CHAIN_Q = chain_eff[7];
`else
  assign CHAIN_Q = chain_q_rand;
`endif

  cfg_chain_loader #(.WIDTH(W), .DIV(DV), .MSB_FIRST(1)) u_dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .CHAIN_CLK(CHAIN_CLK), .CHAIN_D(CHAIN_D), .CHAIN_Q(CHAIN_Q), .CHAIN_LATCH(CHAIN_LATCH),
    .BUSY(BUSY), .DONE(DONE), .MISMATCH(MISMATCH)
  );

  cfg_chain_loader #(.WIDTH(8), .DIV(3), .MSB_FIRST(0)) u_dut3 (
    .CLK(CLK), .RESET(RESET), .IN_VALID(v3), .IN_READY(rdy3), .IN_DATA(d3),
    .CHAIN_CLK(cclk3), .CHAIN_D(cd3), .CHAIN_Q(1'b0), .CHAIN_LATCH(clatch3),
    .BUSY(busy3), .DONE(done3), .MISMATCH(mm3)
  );

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // One cycle of stimulus; the model decides independently whether it is accepted.
  task automatic step(input logic v, input logic [7:0] d);
    IN_VALID     = v;
    IN_DATA      = d;
    chain_q_rand = 1'($urandom);
    chk("in_ready", IN_READY, (cyc >= ready_cyc) ? 1 : 0);
    if (v && (cyc >= ready_cyc)) begin
      sbq.push_back('{data: d, acc: cyc + 1, mm: exp_mm_next});
      ready_cyc = cyc + 1 + LAT;
    end
    @(negedge CLK);
  endtask

  // Monitor: collects serial bits and checks each completed load against the queue.
  always @(negedge CLK) begin
    if (!RESET) begin
      rises     = 0;
      coll      = '0;
      prev_clk  = 1'b0;
      latch_cyc = -1;
    end else begin
      if (!DONE) chk("mismatch_outside_done", MISMATCH, 0);
      if (CHAIN_CLK && !prev_clk) begin
        chk("busy_at_rise", BUSY, 1);
        if (rises == 0) first_rise = cyc;
        last_rise = cyc;
        coll      = {coll[6:0], CHAIN_D};
        rises++;
      end
      prev_clk = CHAIN_CLK;
      if (CHAIN_LATCH) begin
        latch_cyc = cyc;
        chk("latch_has_load", (sbq.size() > 0) ? 1 : 0, 1);
        chk("clk_low_at_latch", CHAIN_CLK, 0);
      end
      if (DONE) begin
        chk("done_has_load", sbq.size(), 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("shifted_word", coll, e.data);
          chk("rise_count", rises, W);
          chk("first_rise_cyc", first_rise, e.acc + DV);
          chk("last_rise_cyc", last_rise, e.acc + DV + 2 * DV * (W - 1));
          chk("latch_cyc", latch_cyc, e.acc + 2 * DV * W);
          chk("done_cyc", cyc, e.acc + LAT - 1);
          chk("mismatch_at_done", MISMATCH, e.mm);
          chk("busy_at_done", BUSY, 1);
        end
        rises     = 0;
        coll      = '0;
        latch_cyc = -1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not complete, %0d checks so far", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         a3, r3, hi3, first3, done3_cyc, a4;
    logic       fb3, p3;
    logic [7:0] c3;

    RESET    = 1'b0;
    IN_VALID = 1'b0;
    IN_DATA  = '0;
    v3       = 1'b0;
    d3       = '0;
    repeat (3) @(negedge CLK);

    chk("rst_in_ready", IN_READY, 0);
    chk("rst_chain_clk", CHAIN_CLK, 0);
    chk("rst_chain_d", CHAIN_D, 0);
    chk("rst_chain_latch", CHAIN_LATCH, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_mismatch", MISMATCH, 0);

    RESET     = 1'b1;
    ready_cyc = cyc + 1;
    @(negedge CLK);

    // DIV=3, LSB first, word 0x01.
    chk("dut3_ready", rdy3, 1);
    v3 = 1'b1;
    d3 = 8'h01;
    a3 = cyc + 1;
    @(negedge CLK);
    v3 = 1'b0;
    d3 = 8'hFE;
    r3 = 0; hi3 = 0; first3 = -1; done3_cyc = -1; fb3 = 1'b0; p3 = 1'b0; c3 = '0;
    for (int i = 0; i < 70 && done3_cyc < 0; i++) begin
      if (cclk3 && !p3) begin
        if (r3 == 0) begin
          first3 = cyc;
          fb3    = cd3;
        end
        r3++;
        c3 = {cd3, c3[7:1]};
      end
      if (cclk3 && r3 == 1) hi3++;
      p3 = cclk3;
      if (done3) done3_cyc = cyc;
      @(negedge CLK);
    end
    chk("dut3_first_bit", fb3, 1);
    chk("dut3_low_len", first3 - a3, 3);
    chk("dut3_high_len", hi3, 3);
    chk("dut3_rises", r3, 8);
    chk("dut3_word", c3, 8'h01);
    chk("dut3_done_cyc", done3_cyc, a3 + 2 * 3 * 8 + 2 - 1);

    // Single load of 0xA5.
    step(1'b1, 8'hA5);
    repeat (25) step(1'b0, 8'($urandom));

    // Valid held: 0x3C, random data while busy, then 0xFF at the next ready slot.
    step(1'b1, 8'h3C);
    repeat (18) step(1'b1, 8'($urandom));
    step(1'b1, 8'hFF);
    repeat (25) step(1'b0, 8'($urandom));

    // Random traffic.
    repeat (400) step(($urandom_range(0, 3) != 0), 8'($urandom));
    for (int i = 0; i < 40 && sbq.size() != 0; i++) step(1'b0, 8'($urandom));
    chk("drain", sbq.size(), 0);
    repeat (3) step(1'b0, 8'($urandom));

    // Reset in the middle of a load.
    a4 = cyc + 1;
    step(1'b1, 8'h69);
    for (int i = 0; i < 20 && cyc < a4 + 5; i++) step(1'b0, 8'($urandom));
    chk("clk_high_before_abort", CHAIN_CLK, 1);
    #2;
    RESET = 1'b0;
    sbq.delete();
    #1;
    chk("abort_chain_clk", CHAIN_CLK, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0);
    chk("abort_latch", CHAIN_LATCH, 0);
    chk("abort_in_ready", IN_READY, 0);
    repeat (3) @(negedge CLK);
    RESET     = 1'b1;
    ready_cyc = cyc + 1;
    @(negedge CLK);
    step(1'b1, 8'h96);
    repeat (25) step(1'b0, 8'($urandom));

`ifdef CFG_CHAIN_READBACK_EN
    step(1'b1, 8'h5A);
    repeat (20) step(1'b0, 8'($urandom));
    step(1'b1, 8'hC3);
    repeat (20) step(1'b0, 8'($urandom));
    step(1'b1, 8'h00);
    repeat (20) step(1'b0, 8'($urandom));
    force_f3    = 1'b1;
    exp_mm_next = 1'b1;
    step(1'b1, 8'h00);
    exp_mm_next = 1'b0;
    repeat (20) step(1'b0, 8'($urandom));
    force_f3 = 1'b0;
`endif

    chk("final_queue_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
